riscv_mc_ctrl: RTL and testbench
================================

# riscv_mc_ctrl

Multi-cycle control FSM for the RV32I core, the sequencing counterpart of the single-cycle control unit. It steps each instruction through fetch, decode, execute, memory and writeback states over a shared ALU, a shared instruction/data memory port and the register file, and it drives every datapath select and write strobe per state. It stalls on a memory ready handshake and latches a sticky error on any opcode it does not support. It sits between the instruction register fields, the ALU `zero` flag and the memory port on one side, and the multi-cycle datapath muxes and enables on the other.

## Interface
Parameters: none. State encoding and opcode constants come from the shared package.

- `clk`  in  1  core clock; all state changes on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `op`  in  7  opcode field from the instruction register
- `funct3`  in  3  funct3 field from the instruction register
- `funct7`  in  7  funct7 field from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  the memory completes the current access this cycle
- `PCWrite`  out  1  PC register enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemWrite`  out  1  memory write strobe
- `IRWrite`  out  1  enable for the instruction register and the OldPC register
- `ResultSrc`  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- `ALUSrcB`  out  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = 4
- `ImmSrc`  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- `RegWrite`  out  1  register file write enable
- `ALUControl`  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- `illegal`  out  1  sticky flag; 1 after decoding an unsupported opcode
- `state`  out  4  current state, for debug

## Operation
- All outputs are Moore outputs of `state`, with three exceptions: strobes gated by `mem_ready`, strobes gated by `zero`, and the function decode.
- Unlisted outputs are 0 in each state.
- FETCH
  - Outputs: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCWrite = `mem_ready`.
  - Stays in FETCH until `mem_ready`=1, then moves to DECODE.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00. This computes the branch target.
  - Next state by `op`:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode -> ILLEGAL
- MEMADR
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - Next state: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD
  - Outputs: AdrSrc=1, ResultSrc=00.
  - Holds until `mem_ready`, then moves to MEMWB.
- MEMWB
  - Outputs: ResultSrc=01, RegWrite=1.
  - Next state: FETCH.
- MEMWRITE
  - Outputs: AdrSrc=1, ResultSrc=00.
  - MemWrite=1 is held until `mem_ready`, then moves to FETCH.
- EXECR
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - Next state: ALUWB.
- EXECI
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - Next state: ALUWB.
- ALUWB
  - Outputs: ResultSrc=00, RegWrite=1.
  - Next state: FETCH.
- BEQ
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = `zero`.
  - Next state: FETCH.
- JAL
  - Outputs: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1.
  - Next state: ALUWB.
- ILLEGAL
  - All strobes are 0 and `illegal`=1.
  - This state is absorbing; only `rst` leaves it.
- ImmSrc is decoded combinationally from `op` in every state:
  - lw, I-type -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - any other opcode -> 00
- ALUControl decode:
  - ALUOp 00 -> add
  - ALUOp 01 -> sub
  - ALUOp 10, decoded by funct3:
    - 000: sub if `op[5]` and `funct7[5]` are both 1, otherwise add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - any other funct3 -> add

## Timing
- Reset:
  - On a rising edge with `rst`=1, `state` becomes FETCH and `illegal` becomes 0.
  - While `rst`=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0, regardless of `mem_ready`.
  - Reset asserted in any state, including mid-stall or ILLEGAL, takes effect at the next edge.
- Instruction latency with zero memory wait:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type, I-type ALU and jal: 4 cycles
  - beq: 3 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Memory handshake:
  - The memory samples the address and MemWrite every cycle.
  - An access completes on the edge where `mem_ready`=1.
  - `mem_ready` is ignored in every other state.
- `op`, `funct3` and `funct7` must be stable from DECODE through the end of the instruction. The instruction register guarantees this.

## Structure
- Package `riscv_mc_pkg` holds:
  - the 4-bit state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, ILLEGAL=11
  - the opcode constants
  - the ALUControl codes
- The top module holds the state register, the next-state logic and the per-state outputs.
- One combinational sub-module, `mc_func_dec`, maps `op`, `funct3`, `funct7` and ALUOp to ImmSrc and ALUControl.

## Test plan
- Reset, then `mem_ready`=1 with add x3,x1,x2 (op 0110011, funct3 000, funct7 0):
  - states FETCH, DECODE, EXECR, ALUWB, FETCH
  - ALUControl=000 in EXECR
  - RegWrite=1 only in ALUWB
- lw with `mem_ready` low for 2 cycles in FETCH and 1 cycle in MEMREAD:
  - 8 cycles total
  - IRWrite pulses exactly once
  - RegWrite only in MEMWB with ResultSrc=01
- sw with `mem_ready`=1:
  - MemWrite=1 for exactly one cycle with AdrSrc=1 and ImmSrc=01
- beq:
  - `zero`=1 gives PCWrite=1 in BEQ
  - `zero`=0 gives PCWrite=0
  - ALUControl=001 in both cases
- jal:
  - PCWrite=1 in JAL, then RegWrite=1 in ALUWB
  - ImmSrc=11
- op 1111111:
  - goes to ILLEGAL, `illegal`=1 and all strobes 0 for 10 cycles
  - `rst`=1 returns it to FETCH with `illegal`=0
  - `rst` held during a FETCH stall keeps IRWrite=0 even with `mem_ready`=1

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: state encoding, opcode constants and ALU codes for the multi-cycle control FSM
package riscv_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/mc_func_dec.sv
// mc_func_dec: immediate format and ALU operation decode from the instruction fields
import riscv_mc_pkg::*;
module mc_func_dec (
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  input  logic [1:0] i_alu_op,
  output logic [1:0] o_imm_src,
  output logic [2:0] o_alu_control
);
  logic [2:0] w_func;
  logic       w_unused;
  assign w_unused = ^{i_funct7[6], i_funct7[4:0]};
  // immediate format by opcode, ALU op by ALUOp with funct3/funct7 refinement for ALU instructions
  always_comb begin
    o_imm_src = i_op == OP_SW ? IMM_S : i_op == OP_BEQ ? IMM_B : i_op == OP_JAL ? IMM_J : IMM_I;
    w_func = i_funct3 == 3'b000 ? ((i_op[5] & i_funct7[5]) ? ALU_SUB : ALU_ADD) :
             i_funct3 == 3'b010 ? ALU_SLT :
             i_funct3 == 3'b110 ? ALU_OR  :
             i_funct3 == 3'b111 ? ALU_AND : ALU_ADD;
    o_alu_control = i_alu_op == ALUOP_SUB ? ALU_SUB : i_alu_op == ALUOP_FUNC ? w_func : ALU_ADD;
  end
endmodule

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle RV32I control FSM driving datapath selects and strobes per state
import riscv_mc_pkg::*;
module riscv_mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state
);
  state_t     r_state, w_next;
  logic       r_illegal;
  logic [1:0] w_alu_op;
  assign state   = r_state;
  assign illegal = r_illegal;
  // state register; the illegal flag sets as the FSM enters ILLEGAL and only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | (w_next == S_ILLEGAL);
    end
  end
  // next state: memory states wait on mem_ready, DECODE dispatches on opcode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:               w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:              w_next = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                                      op == OP_R   ? S_EXECR :
                                      op == OP_I   ? S_EXECI :
                                      op == OP_BEQ ? S_BEQ   :
                                      op == OP_JAL ? S_JAL   : S_ILLEGAL;
      S_MEMADR:              w_next = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:             w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE:            w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
      S_ILLEGAL:             w_next = S_ILLEGAL;
      default:               w_next = S_FETCH;
    endcase
  end
  // per-state datapath selects and strobes; write strobes are suppressed while reset is held
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    w_alu_op  = ALUOP_ADD;
    case (r_state)
      S_FETCH:    begin ResultSrc = 2'b10; ALUSrcB = 2'b10; IRWrite = mem_ready; PCWrite = mem_ready; end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      S_EXECR:    begin ALUSrcA = 2'b10; w_alu_op = ALUOP_FUNC; end
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; w_alu_op = ALUOP_FUNC; end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ:      begin ALUSrcA = 2'b10; w_alu_op = ALUOP_SUB; PCWrite = zero; end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
      default:    ;
    endcase
    PCWrite  = PCWrite & ~rst;
    IRWrite  = IRWrite & ~rst;
    RegWrite = RegWrite & ~rst;
    MemWrite = MemWrite & ~rst;
  end
  mc_func_dec u_dec (
    .i_op         (op),
    .i_funct3     (funct3),
    .i_funct7     (funct7),
    .i_alu_op     (w_alu_op),
    .o_imm_src    (ImmSrc),
    .o_alu_control(ALUControl)
  );
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: directed table, hand sequences and randomized instruction stream against an instruction-level model
import riscv_mc_pkg::*;
module tb_riscv_mc_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = OP_R;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [20:0] w_got;

  riscv_mc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  assign w_got = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, RegWrite, ALUControl, illegal};

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
    int         wf;
    int         wm;
    logic [1:0] imm;
    logic [2:0] ac;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [20:0] mk(input logic [3:0] st, input logic pcw, adr, mw, irw,
                                     input logic [1:0] rs, sa, sb, imm, input logic rw,
                                     input logic [2:0] ac, input logic ill);
    return {st, pcw, adr, mw, irw, rs, sa, sb, imm, rw, ac, ill};
  endfunction

  function automatic logic is_legal(input logic [6:0] o);
    return o == OP_LW || o == OP_SW || o == OP_R || o == OP_I || o == OP_BEQ || o == OP_JAL;
  endfunction

  function automatic logic [1:0] imm_model(input logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_model(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'b000:  return (o[5] && f7[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input logic [20:0] exp, input string nm);
    @(negedge clk);
    n_vec++;
    if (w_got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, w_got, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input int wf, input int wm, input logic [1:0] imm,
                           input logic [2:0] ac, input string nm);
    op = o; funct3 = f3; funct7 = f7; zero = z;
    repeat (wf) begin
      mem_ready = 1'b0;
      chk(mk(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 0, ALU_ADD, 0), {nm, "/fetch_wait"});
    end
    mem_ready = 1'b1;
    chk(mk(S_FETCH, 1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 0, ALU_ADD, 0), {nm, "/fetch"});
    mem_ready = 1'($urandom);
    chk(mk(S_DECODE, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 0, ALU_ADD, 0), {nm, "/decode"});
    if (o == OP_LW || o == OP_SW) begin
      mem_ready = 1'($urandom);
      chk(mk(S_MEMADR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 0, ALU_ADD, 0), {nm, "/memadr"});
    end
    if (o == OP_LW) begin
      repeat (wm) begin
        mem_ready = 1'b0;
        chk(mk(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 0, ALU_ADD, 0), {nm, "/memread_wait"});
      end
      mem_ready = 1'b1;
      chk(mk(S_MEMREAD, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 0, ALU_ADD, 0), {nm, "/memread"});
      mem_ready = 1'($urandom);
      chk(mk(S_MEMWB, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, imm, 1, ALU_ADD, 0), {nm, "/memwb"});
    end else if (o == OP_SW) begin
      repeat (wm) begin
        mem_ready = 1'b0;
        chk(mk(S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, imm, 0, ALU_ADD, 0), {nm, "/memwrite_wait"});
      end
      mem_ready = 1'b1;
      chk(mk(S_MEMWRITE, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, imm, 0, ALU_ADD, 0), {nm, "/memwrite"});
    end else if (o == OP_R || o == OP_I || o == OP_JAL) begin
      mem_ready = 1'($urandom);
      if (o == OP_R)
        chk(mk(S_EXECR, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, 0, ac, 0), {nm, "/execr"});
      else if (o == OP_I)
        chk(mk(S_EXECI, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 0, ac, 0), {nm, "/execi"});
      else
        chk(mk(S_JAL, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, 0, ALU_ADD, 0), {nm, "/jal"});
      mem_ready = 1'($urandom);
      chk(mk(S_ALUWB, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 1, ALU_ADD, 0), {nm, "/aluwb"});
    end else if (o == OP_BEQ) begin
      mem_ready = 1'($urandom);
      chk(mk(S_BEQ, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, 0, ALU_SUB, 0), {nm, "/beq"});
    end else begin
      repeat (10) begin
        mem_ready = 1'($urandom);
        chk(mk(S_ILLEGAL, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 0, ALU_ADD, 1), {nm, "/illegal"});
      end
    end
  endtask

  initial begin
    logic [6:0] ops [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
    logic [6:0] o;
    logic [2:0] f3;
    logic [6:0] f7;
    tbl.push_back('{OP_R,   3'b000, 7'h00, 1'b0, 0, 0, 2'b00, 3'b000});
    tbl.push_back('{OP_R,   3'b000, 7'h20, 1'b0, 0, 0, 2'b00, 3'b001});
    tbl.push_back('{OP_R,   3'b010, 7'h00, 1'b0, 0, 0, 2'b00, 3'b101});
    tbl.push_back('{OP_R,   3'b110, 7'h00, 1'b0, 0, 0, 2'b00, 3'b011});
    tbl.push_back('{OP_R,   3'b111, 7'h00, 1'b0, 0, 0, 2'b00, 3'b010});
    tbl.push_back('{OP_R,   3'b100, 7'h00, 1'b0, 0, 0, 2'b00, 3'b000});
    tbl.push_back('{OP_I,   3'b000, 7'h20, 1'b0, 0, 0, 2'b00, 3'b000});
    tbl.push_back('{OP_I,   3'b111, 7'h00, 1'b0, 1, 0, 2'b00, 3'b010});
    tbl.push_back('{OP_LW,  3'b010, 7'h00, 1'b0, 2, 1, 2'b00, 3'b000});
    tbl.push_back('{OP_SW,  3'b010, 7'h00, 1'b0, 0, 0, 2'b01, 3'b000});
    tbl.push_back('{OP_SW,  3'b010, 7'h00, 1'b1, 1, 2, 2'b01, 3'b000});
    tbl.push_back('{OP_BEQ, 3'b000, 7'h00, 1'b1, 0, 0, 2'b10, 3'b001});
    tbl.push_back('{OP_BEQ, 3'b000, 7'h00, 1'b0, 0, 0, 2'b10, 3'b001});
    tbl.push_back('{OP_JAL, 3'b000, 7'h00, 1'b0, 0, 0, 2'b11, 3'b000});
    // reset held with mem_ready high: FETCH, no strobes
    @(posedge clk);
    #1;
    chk(mk(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, ALU_ADD, 0), "reset");
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++)
      run_instr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].wf, tbl[i].wm,
                tbl[i].imm, tbl[i].ac, $sformatf("vec%0d", i));
    // unsupported opcode, reset out of ILLEGAL, reset during a fetch stall
    run_instr(7'h7f, 3'b000, 7'h00, 1'b0, 0, 0, 2'b00, 3'b000, "illegal");
    rst = 1'b1; mem_ready = 1'b1;
    chk(mk(S_ILLEGAL, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, ALU_ADD, 1), "rst_in_illegal");
    rst = 1'b0; mem_ready = 1'b0;
    chk(mk(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, ALU_ADD, 0), "after_rst");
    rst = 1'b1; mem_ready = 1'b1;
    chk(mk(S_FETCH, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, ALU_ADD, 0), "rst_stall");
    rst = 1'b0;
    run_instr(OP_R, 3'b000, 7'h00, 1'b0, 0, 0, 2'b00, 3'b000, "post_rst_add");
    // randomized instruction stream with random memory waits
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 12) == 0) begin
        do o = 7'($urandom); while (is_legal(o));
      end else
        o = ops[$urandom_range(0, 5)];
      f3 = 3'($urandom);
      f7 = $urandom_range(0, 1) ? 7'h20 : 7'($urandom);
      run_instr(o, f3, f7, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                imm_model(o), alu_model(o, f3, f7), $sformatf("rand%0d", i));
      if (!is_legal(o)) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
